ledg_pwm_driver: RTL and testbench
==================================

// Module: ledg_pwm_driver
// PURPOSE
//  Downstream stage of the LEDG PIO: takes the 9-bit PIO out_port as led_in and drives the LEDG pins.
//  Adds global PWM brightness and optional blink, configured through a small Avalon-MM slave.
//  Sits between the PIO and the top-level LEDG pins; with CTRL.enable=0 the PIO value passes straight through.
// PARAMETERS
//  WIDTH         9   number of LEDs, matching the PIO width
//  PWM_BITS      8   PWM counter width; a frame is 2^PWM_BITS PWM steps
//  PRESCALE_DIV  64  clk cycles per PWM step (>=1)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  led_in     in   WIDTH  LED pattern from the PIO out_port
//  address    in   2      Avalon-MM word address
//  chipselect in   1      Avalon-MM select
//  write_n    in   1      Avalon-MM write strobe, active low
//  writedata  in   32     Avalon-MM write data
//  readdata   out  32     Avalon-MM read data; combinational, zero-extended
//  led_out    out  WIDTH  registered LED pin drive
// BEHAVIOUR
//  Registers (a write occurs when chipselect & ~write_n):
//   0 CTRL:  [0] enable, [1] blink_en; reset 0
//   1 DUTY:  [PWM_BITS:0]; reset 2^PWM_BITS (full on); writes above 2^PWM_BITS saturate to 2^PWM_BITS
//   2 BLINK: [15:0] blink period in frames; reset 0; a period of 0 behaves as 1
//   3 STATUS (read-only; writes ignored): [0] blink_phase, [8+:PWM_BITS] pwm_cnt
//  Timebase:
//   - presc counts 0..PRESCALE_DIV-1; step = (presc == PRESCALE_DIV-1)
//   - pwm_cnt increments on step; frame_end = step & (pwm_cnt == all-ones), after which pwm_cnt wraps to 0
//  Duty shadow:
//   - duty_sh loads from DUTY only on frame_end, so there are no mid-frame glitches
//   - a DUTY write in the same cycle as frame_end is applied at the following frame_end
//   - pwm_on = (pwm_cnt < duty_sh); duty_sh=0 gives always off, duty_sh=2^PWM_BITS gives always on
//  Blink:
//   - on frame_end, if frame_cnt >= period-1: toggle blink_phase and clear frame_cnt; otherwise increment frame_cnt
//   - the >= compare makes a shrunken period take effect on the next frame_end
//   - blink_en=0 holds blink_phase=1 and frame_cnt=0
//  Output:
//   - led_out <= enable ? (led_in & {WIDTH{pwm_on & blink_phase}}) : led_in
//   - latency is 1 clk from led_in to led_out
//  Enable rising edge (a CTRL write with enable 0->1):
//   - same edge clears presc, pwm_cnt and frame_cnt, sets blink_phase=1 and loads duty_sh from DUTY immediately
//  Enable=0: timebase held in reset state, led_out is the bypass path
//  Reset (asynchronous): led_out=0, all counters 0, blink_phase=1, duty_sh=2^PWM_BITS, registers at reset values
//   - reset asserted mid-frame takes effect immediately, with no frame completion
// CONFIGURATION
//  Macro LEDG_GAMMA_EN:
//   - defined: duty_sh loads gamma(DUTY) = (DUTY*DUTY) >> PWM_BITS, computed in the load path
//     (gamma(2^PWM_BITS) = 2^PWM_BITS, gamma(0) = 0); STATUS and DUTY readback still show the linear value
//   - undefined: duty_sh loads DUTY unchanged (linear)
// STRUCTURE
//  Package ledg_pwm_pkg:
//   - register address localparams (CTRL/DUTY/BLINK/STATUS)
//   - CTRL bit indices (CTRL_EN=0, CTRL_BLINK=1)
//   - reset value constants
//  Sub-module ledg_pwm_timebase: presc + pwm_cnt; outputs step, frame_end, pwm_cnt; inputs clear, run
//  Top level: register file, read mux, duty shadow (and gamma), blink logic, output register
// TESTING  (bench uses PRESCALE_DIV=4, PWM_BITS=8, so one frame = 1024 clk)
//  1 Reset: assert reset_n=0 -> led_out=0; read addr1=32'h100, addr0=0, addr2=0
//  2 Bypass: CTRL=0, led_in=9'h1A5 -> led_out=9'h1A5 exactly 1 clk later; led_in change tracked at 1 clk
//  3 PWM: CTRL=1, DUTY=64, led_in=9'h1FF -> each frame led_out=9'h1FF for 256 clk, then 0 for 768 clk
//  4 Limits: DUTY=0 -> led_out always 0; write DUTY=300 -> reads 256 and led_out always equals led_in
//  5 Blink: DUTY=256, BLINK=3, CTRL=3 -> led_out toggles between led_in and 0 every 3072 clk, starting on
//  6 Shadow: write DUTY=200 mid-frame at DUTY=64 -> current frame keeps 256 on-clk; next frame has 800 on-clk;
//    with LEDG_GAMMA_EN, DUTY=128 -> 64 steps (256 clk) on per frame

Source files
------------

// File: rtl/ledg_pwm_pkg.sv
// ledg_pwm_pkg
//   Shared constants for the LEDG PWM driver: Avalon-MM register map,
//   CTRL bit positions and register reset values.
//   Optional build macro used by the driver: LEDG_GAMMA_EN.
package ledg_pwm_pkg;

   // Register word addresses
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // CTRL bit indices
   localparam int CTRL_EN    = 0;
   localparam int CTRL_BLINK = 1;

   // Reset values
   localparam logic [1:0]  CTRL_RESET  = 2'b00;
   localparam logic [15:0] BLINK_RESET = 16'd0;

   // DUTY reset value is "full on", i.e. 2^pwm_bits
   function automatic logic [31:0] duty_reset(input int pwm_bits);
      return 32'd1 << pwm_bits;
   endfunction

endpackage

// File: rtl/ledg_pwm_timebase.sv
// ledg_pwm_timebase
//   Prescaler plus PWM step counter. One frame is 2^PWM_BITS steps of
//   PRESCALE_DIV clocks each.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous return to the start of a frame
//   run          : count enable; when low the counters are held at zero
//   step         : one-cycle pulse at the last prescaler count
//   frame_end    : step on the last PWM count of a frame
//   pwm_cnt      : current PWM step within the frame
module ledg_pwm_timebase #(
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE_DIV = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                run,
   output logic                step,
   output logic                frame_end,
   output logic [PWM_BITS-1:0] pwm_cnt
);
   import ledg_pwm_pkg::*;

   // A divider of 1 still needs a one-bit prescaler register (always 0)
   localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE_DIV - 1);

   logic [PW-1:0] presc;

   assign step      = run & ~clear & (presc == PRESC_MAX);
   assign frame_end = step & (pwm_cnt == '1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else if (clear || !run) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else if (step) begin
         presc   <= '0;
         pwm_cnt <= pwm_cnt + 1'b1;   // wraps to 0 after frame_end
      end else begin
         presc   <= presc + 1'b1;
      end
   end

endmodule

// File: rtl/ledg_pwm_driver.sv
// ledg_pwm_driver
//   Sits between the LEDG PIO out_port and the LEDG pins. Adds global PWM
//   brightness and optional blink, configured through an Avalon-MM slave.
//   With CTRL.enable=0 the PIO pattern passes straight through (1 clk).
//   Build macro LEDG_GAMMA_EN: when defined, the duty shadow loads the
//   squared duty (DUTY*DUTY >> PWM_BITS); readback stays linear.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   led_in       : LED pattern from the PIO
//   address, chipselect, write_n, writedata : Avalon-MM slave write side
//   readdata     : combinational, zero-extended register readback
//   led_out      : registered LED pin drive
// Bus semantics: a write happens on any clock edge where chipselect is high
// and write_n is low; there is no wait state. Reads have no strobe: readdata
// always reflects the addressed register.
module ledg_pwm_driver #(
   parameter int WIDTH        = 9,
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE_DIV = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] led_in,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] led_out
);
   import ledg_pwm_pkg::*;

   localparam int DW = PWM_BITS + 1;
   localparam logic [DW-1:0] DUTY_FULL = DW'(duty_reset(PWM_BITS));

   logic                ctrl_en;
   logic                ctrl_blink;
   logic [DW-1:0]       duty_reg;
   logic [15:0]         blink_reg;
   logic [DW-1:0]       duty_sh;
   logic                blink_phase;
   logic [15:0]         frame_cnt;
   logic [15:0]         period_m1;
   logic                wr;
   logic                en_rise;
   logic                step;
   logic                frame_end;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on;
   logic                unused_step;

   assign unused_step = step;

   // Duty value as loaded into the shadow register
   function automatic logic [DW-1:0] shape(input logic [DW-1:0] d);
`ifdef LEDG_GAMMA_EN
      logic [2*DW-1:0] sq;
      sq = {{DW{1'b0}}, d} * {{DW{1'b0}}, d};
      return DW'(sq >> PWM_BITS);
`else
      return d;
`endif
   endfunction

   assign wr      = chipselect & ~write_n;
   // Enable 0->1 restarts the frame from a clean state on the same edge
   assign en_rise = wr & (address == ADDR_CTRL) & writedata[CTRL_EN] & ~ctrl_en;

   ledg_pwm_timebase #(
      .PWM_BITS     (PWM_BITS),
      .PRESCALE_DIV (PRESCALE_DIV)
   ) u_timebase (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (en_rise),
      .run       (ctrl_en),
      .step      (step),
      .frame_end (frame_end),
      .pwm_cnt   (pwm_cnt)
   );

   // Register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en    <= CTRL_RESET[CTRL_EN];
         ctrl_blink <= CTRL_RESET[CTRL_BLINK];
         duty_reg   <= DUTY_FULL;
         blink_reg  <= BLINK_RESET;
      end else if (wr) begin
         case (address)
            ADDR_CTRL: begin
               ctrl_en    <= writedata[CTRL_EN];
               ctrl_blink <= writedata[CTRL_BLINK];
            end
            ADDR_DUTY: begin
               if (writedata > 32'(DUTY_FULL)) duty_reg <= DUTY_FULL;
               else                            duty_reg <= writedata[DW-1:0];
            end
            ADDR_BLINK: blink_reg <= writedata[15:0];
            default: ;   // STATUS is read-only
         endcase
      end
   end

   // Read mux
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:  begin
            readdata[CTRL_EN]    = ctrl_en;
            readdata[CTRL_BLINK] = ctrl_blink;
         end
         ADDR_DUTY:  readdata[DW-1:0] = duty_reg;
         ADDR_BLINK: readdata[15:0]   = blink_reg;
         default: begin
            readdata[0]             = blink_phase;
            readdata[8 +: PWM_BITS] = pwm_cnt;
         end
      endcase
   end

   // Duty shadow: only changes at frame boundaries (or enable restart), so a
   // DUTY write never truncates or stretches the frame in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  duty_sh <= DUTY_FULL;
      else if (en_rise || frame_end) duty_sh <= shape(duty_reg);
   end

   // Period 0 is treated as 1
   assign period_m1 = (blink_reg == 16'd0) ? 16'd0 : blink_reg - 16'd1;

   // Blink: >= compare lets a shortened period take effect at the next frame_end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_phase <= 1'b1;
         frame_cnt   <= '0;
      end else if (!ctrl_blink || !ctrl_en || en_rise) begin
         blink_phase <= 1'b1;
         frame_cnt   <= '0;
      end else if (frame_end) begin
         if (frame_cnt >= period_m1) begin
            blink_phase <= ~blink_phase;
            frame_cnt   <= '0;
         end else begin
            frame_cnt   <= frame_cnt + 16'd1;
         end
      end
   end

   assign pwm_on = ({1'b0, pwm_cnt} < duty_sh);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     led_out <= '0;
      else if (ctrl_en) led_out <= led_in & {WIDTH{pwm_on & blink_phase}};
      else              led_out <= led_in;
   end

endmodule

// File: tb/tb_ledg_pwm_driver.sv
module tb_ledg_pwm_driver;
   localparam int WIDTH = 9;
   localparam int PWM_BITS = 8;
   localparam int PRESC = 4;
   localparam int FRAME = 1024;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] led_in;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] led_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   ledg_pwm_driver #(
      .WIDTH        (WIDTH),
      .PWM_BITS     (PWM_BITS),
      .PRESCALE_DIV (PRESC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_in     (led_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_out    (led_out)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // expected on-clocks per frame for a given DUTY write value
   function automatic int exp_on_clk(input int d);
      int x;
      x = (d > 256) ? 256 : d;
`ifdef LEDG_GAMMA_EN
      x = (x * x) >> PWM_BITS;
`endif
      return x * PRESC;
   endfunction

   // driver tasks
   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic restart(input logic [31:0] ctrl);
      write_reg(2'd0, 32'd0);
      write_reg(2'd0, ctrl);
   endtask

   // Each frame is sampled from the first led_out update after the enable
   // edge; the expected on-count is popped from the scoreboard.
   task automatic measure_frames(input int n, input logic [WIDTH-1:0] pat, input string tag);
      for (int f = 0; f < n; f++) begin
         int on_cnt = 0;
         int bad = 0;
         int first_off = FRAME;
         logic [31:0] exp;
         for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            if (led_out === pat) on_cnt++;
            else if (led_out === '0) begin
               if (first_off == FRAME) first_off = i;
            end else bad++;
         end
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
         check($sformatf("%s_f%0d_on", tag, f), on_cnt, exp);
         check($sformatf("%s_f%0d_first_off", tag, f), first_off, exp);
         check($sformatf("%s_f%0d_bad", tag, f), bad, 0);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [WIDTH-1:0] v, prev;

      reset_n    = 1'b0;
      led_in     = '0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_led_out", led_out, 0);
      read_reg(2'd1, rd); check("rst_duty", rd, 32'h100);
      read_reg(2'd0, rd); check("rst_ctrl", rd, 0);
      read_reg(2'd2, rd); check("rst_blink", rd, 0);
      read_reg(2'd3, rd); check("rst_status", rd, 1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // bypass: exactly one clock of latency
      prev = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v = (i == 0) ? 9'h1A5 : WIDTH'($urandom_range(0, 511));
         led_in = v;
         exp_q.push_back(32'(v));
         #1;
         check("byp_hold", led_out, prev);
         @(posedge clk);
         #1;
         check("byp", led_out, exp_q.pop_front());
         prev = v;
      end

      // PWM at DUTY=64
      led_in = 9'h1FF;
      write_reg(2'd1, 32'd64);
      restart(32'd1);
      exp_q.push_back(exp_on_clk(64));
      exp_q.push_back(exp_on_clk(64));
      measure_frames(2, 9'h1FF, "pwm64");

      // limits: DUTY=0 and saturating DUTY=300
      write_reg(2'd1, 32'd0);
      restart(32'd1);
      exp_q.push_back(0);
      measure_frames(1, 9'h1FF, "duty0");
      write_reg(2'd1, 32'd300);
      read_reg(2'd1, rd); check("duty_sat", rd, 32'd256);
      led_in = 9'h0F3;
      restart(32'd1);
      exp_q.push_back(FRAME);
      measure_frames(1, 9'h0F3, "dutyfull");

      // blink period 3 at full duty
      led_in = 9'h1FF;
      write_reg(2'd1, 32'd256);
      write_reg(2'd2, 32'd3);
      restart(32'd3);
      repeat (3) exp_q.push_back(FRAME);
      measure_frames(3, 9'h1FF, "blink_on");
      read_reg(2'd3, rd); check("blink_status_off", rd, 0);
      repeat (3) exp_q.push_back(0);
      measure_frames(3, 9'h1FF, "blink_off");
      read_reg(2'd3, rd); check("blink_status_on", rd, 1);

      // blink period 0 behaves as 1
      write_reg(2'd2, 32'd0);
      restart(32'd3);
      exp_q.push_back(FRAME);
      exp_q.push_back(0);
      measure_frames(2, 9'h1FF, "blink_p0");

      // duty shadow: mid-frame write only affects the next frame
      write_reg(2'd1, 32'd64);
      restart(32'd1);
      exp_q.push_back(exp_on_clk(64));
      exp_q.push_back(exp_on_clk(200));
      fork
         measure_frames(2, 9'h1FF, "shadow");
         begin
            repeat (500) @(posedge clk);
            write_reg(2'd1, 32'd200);
         end
      join
      read_reg(2'd1, rd); check("shadow_duty_rd", rd, 32'd200);

      // asynchronous reset mid-frame
      restart(32'd1);
      repeat (100) @(posedge clk);
      #2;
      check("pre_rst_led", led_out, 32'h1FF);
      reset_n = 1'b0;
      #1;
      check("midrst_led", led_out, 0);
      read_reg(2'd3, rd); check("midrst_status", rd, 1);
      read_reg(2'd1, rd); check("midrst_duty", rd, 32'h100);
      read_reg(2'd0, rd); check("midrst_ctrl", rd, 0);
      #10;
      reset_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
